mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-port arbiter that shares the CPU's single Avalon memory-mapped master port between the instruction-fetch requester and the load/store (data) requester inside `mips_cpu_bus`. It latches the winning request, runs one Avalon read or write transaction with full `waitrequest` handling, then returns read data and a completion pulse to the owner. Arbitration is round-robin, so neither port starves.

## Interface

- No parameters. Data width 32, address width 32, byteenable width 4, all fixed.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `i_req` in 1: instruction port requests a 32-bit read.
- `i_address` in 32: instruction read address; sampled when the request is granted.
- `i_done` out 1: one-cycle pulse; instruction read complete.
- `i_rdata` out 32: instruction read data; valid only while `i_done`=1.
- `d_req` in 1: data port requests a transaction.
- `d_write` in 1: 1 = write, 0 = read; sampled when the request is granted.
- `d_address` in 32: data address; sampled when the request is granted.
- `d_writedata` in 32: write data; sampled when the request is granted.
- `d_byteenable` in 4: byte lanes; sampled when the request is granted.
- `d_done` out 1: one-cycle pulse; data transaction complete.
- `d_rdata` out 32: data read result; valid only while `d_done`=1 on a read.
- `address` out 32: Avalon address, bits [1:0] always 0.
- `read` out 1: Avalon read strobe.
- `write` out 1: Avalon write strobe.
- `writedata` out 32: Avalon write data.
- `byteenable` out 4: Avalon byte enables.
- `waitrequest` in 1: Avalon slave stall.
- `readdata` in 32: Avalon read data; valid the cycle after the read is accepted.

## Operation

- States:
  - IDLE: no transaction in progress.
  - ISSUE: bus strobe asserted.
  - RDATA: read data returning.
- IDLE, with `i_req` or `d_req` high:
  - Pick the winner.
  - Latch its command into `cmd_addr`, `cmd_wr`, `cmd_wdata`, `cmd_be` and `owner`.
  - Go to ISSUE.
  - With no request, stay in IDLE.
- Arbitration is round-robin on the `last_owner` register:
  - If only one port requests, that port wins.
  - If both request, the port that is not `last_owner` wins.
  - `last_owner` updates when a transaction completes.
  - `last_owner` resets to D, so the instruction port wins the first tie.
- Instruction commands are always a read with `cmd_be` = 4'b1111.
- ISSUE:
  - Drive `address` = {cmd_addr[31:2],2'b00}, `writedata` = `cmd_wdata`, `byteenable` = `cmd_be`.
  - Assert `read` = !cmd_wr, `write` = cmd_wr.
  - Hold all of these stable while `waitrequest`=1.
  - When `waitrequest`=0, the transaction is accepted:
    - write: pulse the owner's `done` in that same cycle and go to IDLE.
    - read: go to RDATA.
- RDATA:
  - Owner's `rdata` = `readdata`, driven combinationally.
  - Pulse the owner's `done`.
  - Go to IDLE.
- Outside RDATA, `i_rdata` and `d_rdata` are 0.
- The non-owner's `done` is never asserted.
- Requester contract:
  - Hold `req` high until `done`, then drop it by the next edge.
  - If `req` is still high in the following IDLE, that is a new request.
  - Command inputs may change freely after the grant; they are not re-read.
- `d_req` with `d_byteenable`=0 is still issued on the bus unchanged.

## Timing

- Reset values:
  - State IDLE, `last_owner` D.
  - `read`, `write`, `i_done`, `d_done` all 0.
  - `address`, `writedata`, `byteenable`, `i_rdata`, `d_rdata` all 0.
- Bus strobes and address come from registered state, with no combinational path from `*_req` to the bus.
- Read with zero wait: request seen in cycle N (IDLE).
  - N+1: ISSUE, `read`=1, accepted.
  - N+2: RDATA, `done`=1.
  - Next request can be granted in N+3.
- Write with zero wait: request in N; `write`=1 and `done`=1 both in N+1; IDLE in N+2.
- Each `waitrequest`=1 cycle in ISSUE adds exactly one cycle.
- Minimum spacing between bus transactions: one IDLE cycle.
- Both requests arriving in the same cycle: one is granted. The other waits, provided its `req` stays high, and is granted in the next IDLE.
- `reset` asserted in any state: IDLE and all outputs 0 after the next edge. The in-flight transaction is abandoned and no `done` is pulsed.

## Test plan

- Instruction read: `i_req`=1, `i_address`=32'hBFC0_0000, `waitrequest`=0, `readdata`=32'h2402_0005 in the RDATA cycle.
  - `read`=1 one cycle after the request.
  - `i_done`=1 with `i_rdata`=32'h2402_0005 two cycles after the request.
- Data write with 3 wait cycles: `d_write`=1, `d_address`=32'h0000_1003, `d_byteenable`=4'b0011.
  - `address`=32'h0000_1000 and `write`=1 held for 4 cycles.
  - `d_done` asserted in the fourth `write` cycle only.
- Simultaneous `i_req` and `d_req` right after reset, held high until each port's own `done`:
  - instruction served first, data second.
  - Repeat: data first.
- `d_req` held continuously for 4 transactions while `i_req` is also held: grants alternate D, I, D, I.
- `reset` asserted in ISSUE while `waitrequest`=1:
  - next cycle `read`=`write`=0 and state IDLE.
  - no `done` ever pulsed for that request.
- Read with `waitrequest`=1 for 2 cycles: `d_rdata` equals the `readdata` presented one cycle after acceptance; `d_done` is high for exactly one cycle.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between the instruction-fetch
// and load/store requesters of mips_cpu_bus; one transaction in flight at a time.
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_address,
    output logic        i_done,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_done,
    output logic [31:0] d_rdata,

    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,

    output logic [1:0]  dbg_state
);

    // Handshake: a requester holds *_req high until its one-cycle *_done pulse and
    // drops it by the following edge; commands are sampled only at the grant edge.
    // On the bus, strobes/address/data stay stable while waitrequest=1, and read
    // data is taken in the cycle after the read is accepted.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    state_t      state;
    logic        owner;
    logic        last_owner;
    logic [31:0] cmd_addr;
    logic        cmd_wr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_be;

    logic        grant_d;
    logic        accept;
    logic        done_any;

    // On a tie the port that did not finish last wins.
    always_comb begin
        grant_d = 1'b0;
        if (i_req && d_req) begin
            grant_d = (last_owner == OWNER_I);
        end else begin
            grant_d = d_req;
        end
    end

    assign accept   = (state == ISSUE) && !waitrequest;
    assign done_any = !reset && ((accept && cmd_wr) || (state == RDATA));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWNER_I;
            last_owner <= OWNER_D;
            cmd_addr   <= 32'h0;
            cmd_wr     <= 1'b0;
            cmd_wdata  <= 32'h0;
            cmd_be     <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner <= grant_d;
                        state <= ISSUE;
                        if (grant_d) begin
                            cmd_addr  <= d_address;
                            cmd_wr    <= d_write;
                            cmd_wdata <= d_writedata;
                            cmd_be    <= d_byteenable;
                        end else begin
                            cmd_addr  <= i_address;
                            cmd_wr    <= 1'b0;
                            cmd_wdata <= 32'h0;
                            cmd_be    <= 4'b1111;
                        end
                    end
                end
                ISSUE: begin
                    if (!waitrequest) begin
                        if (cmd_wr) begin
                            state      <= IDLE;
                            last_owner <= owner;
                        end else begin
                            state <= RDATA;
                        end
                    end
                end
                RDATA: begin
                    state      <= IDLE;
                    last_owner <= owner;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus side is decoded from registered state only, never from *_req.
    assign address    = (state == ISSUE) ? (cmd_addr & 32'hFFFF_FFFC) : 32'h0;
    assign read       = (state == ISSUE) && !cmd_wr;
    assign write      = (state == ISSUE) && cmd_wr;
    assign writedata  = (state == ISSUE) ? cmd_wdata : 32'h0;
    assign byteenable = (state == ISSUE) ? cmd_be : 4'h0;

    assign i_done  = done_any && (owner == OWNER_I);
    assign d_done  = done_any && (owner == OWNER_D);
    assign i_rdata = ((state == RDATA) && (owner == OWNER_I)) ? readdata : 32'h0;
    assign d_rdata = ((state == RDATA) && (owner == OWNER_D)) ? readdata : 32'h0;

    assign dbg_state = state;

    a_done_onehot: assert property (@(posedge clk) disable iff (reset) !(i_done && d_done));
    a_strobe_excl: assert property (@(posedge clk) disable iff (reset) !(read && write));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a small Avalon slave model, a bus and a
// completion scoreboard fed by the stimulus, and cycle-exact timing checks.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_address;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic        d_done;
    logic [31:0] d_rdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fails = 0;
    int done_count = 0;

    // Bus entry: {wr, addr[31:0], wdata[31:0], be[3:0]}; response: {is_d, rdata}.
    logic [68:0] bus_q[$];
    logic [32:0] rsp_q[$];

    logic        i_seen = 1'b0;
    logic        d_seen = 1'b0;
    logic        auto_drop = 1'b1;
    int          wait_cycles = 0;
    logic [31:0] rd_value = 32'h0;

    mem_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_address(i_address), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_write(d_write), .d_address(d_address),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_done(d_done), .d_rdata(d_rdata),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
        .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fails++;
        $display("FAIL %s", name);
    endtask

    // Avalon slave: stalls each command for wait_cycles, returns rd_value next cycle.
    initial begin
        int wcnt;
        logic rd_pending;
        wcnt = 0;
        rd_pending = 1'b0;
        waitrequest = 1'b0;
        readdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            readdata = rd_pending ? rd_value : 32'hDEAD_BEEF;
            rd_pending = 1'b0;
            if (read || write) begin
                if (wcnt < wait_cycles) begin
                    waitrequest = 1'b1;
                    wcnt++;
                end else begin
                    waitrequest = 1'b0;
                    wcnt = 0;
                    rd_pending = read;
                end
            end else begin
                waitrequest = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [68:0] b;
        logic [32:0] r;
        forever begin
            @(negedge clk);
            i_seen = i_done;
            d_seen = d_done;
            if ((read || write) && !waitrequest) begin
                if (bus_q.size() == 0) begin
                    fail("bus: unexpected transaction");
                end else begin
                    b = bus_q.pop_front();
                    check("bus write", write, b[68]);
                    check("bus read", read, !b[68]);
                    check("bus address", address, b[67:36]);
                    check("bus byteenable", byteenable, b[3:0]);
                    if (b[68]) check("bus writedata", writedata, b[35:4]);
                end
            end
            if (i_done || d_done) begin
                done_count++;
                if (rsp_q.size() == 0) begin
                    fail("done: unexpected completion");
                end else begin
                    r = rsp_q.pop_front();
                    check("done owner", d_done, r[32]);
                    check("done both ports", i_done && d_done, 0);
                    check("i_rdata", i_rdata, r[32] ? 32'h0 : r[31:0]);
                    check("d_rdata", d_rdata, r[32] ? r[31:0] : 32'h0);
                end
            end else if (!reset && (i_rdata !== 32'h0 || d_rdata !== 32'h0)) begin
                fail("rdata nonzero outside done");
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
        if (auto_drop) begin
            if (i_seen) i_req = 1'b0;
            if (d_seen) d_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_until(input int target, input int budget);
        int k;
        k = 0;
        while (done_count < target && k < budget) begin
            tick();
            k++;
        end
        if (done_count < target) fail("timeout waiting for done");
    endtask

    task automatic set_d(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
        d_req = 1'b1;
        d_write = wr;
        d_address = addr;
        d_writedata = wd;
        d_byteenable = be;
    endtask

    task automatic set_i(input logic [31:0] addr);
        i_req = 1'b1;
        i_address = addr;
    endtask

    initial begin
        int hits;
        reset = 1'b1;
        i_req = 1'b0; i_address = 32'h0;
        d_req = 1'b0; d_write = 1'b0; d_address = 32'h0;
        d_writedata = 32'h0; d_byteenable = 4'h0;
        do_reset();

        check("reset read", read, 0);
        check("reset write", write, 0);
        check("reset i_done", i_done, 0);
        check("reset d_done", d_done, 0);
        check("reset address", address, 0);
        check("reset writedata", writedata, 0);
        check("reset byteenable", byteenable, 0);
        check("reset i_rdata", i_rdata, 0);
        check("reset d_rdata", d_rdata, 0);
        check("reset state", dbg_state, 0);

        // Instruction read, zero wait
        wait_cycles = 0;
        rd_value = 32'h2402_0005;
        bus_q.push_back({1'b0, 32'hBFC0_0000, 32'h0, 4'hF});
        rsp_q.push_back({1'b0, 32'h2402_0005});
        set_i(32'hBFC0_0000);
        tick();
        check("t1 read strobe", read, 1);
        check("t1 address", address, 32'hBFC0_0000);
        check("t1 i_done early", i_done, 0);
        tick();
        check("t1 i_done", i_done, 1);
        check("t1 i_rdata", i_rdata, 32'h2402_0005);
        check("t1 read dropped", read, 0);
        tick();
        check("t1 back to idle", dbg_state, 0);

        // Data write with 3 wait cycles, unaligned address
        wait_cycles = 3;
        bus_q.push_back({1'b1, 32'h0000_1000, 32'hA5A5_1234, 4'b0011});
        rsp_q.push_back({1'b1, 32'h0});
        set_d(1'b1, 32'h0000_1003, 32'hA5A5_1234, 4'b0011);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) d_address = 32'hFFFF_FFFF;
            check("t2 write held", write, 1);
            check("t2 address held", address, 32'h0000_1000);
            check("t2 d_done timing", d_done, (k == 4));
        end
        tick();
        check("t2 write released", write, 0);
        check("t2 idle", dbg_state, 0);
        wait_cycles = 0;

        // Tie right after reset: instruction first
        do_reset();
        rd_value = 32'h1111_1111;
        bus_q.push_back({1'b0, 32'h0000_0100, 32'h0, 4'hF});
        bus_q.push_back({1'b1, 32'h0000_0200, 32'h2222_2222, 4'hF});
        rsp_q.push_back({1'b0, 32'h1111_1111});
        rsp_q.push_back({1'b1, 32'h0});
        set_i(32'h0000_0100);
        set_d(1'b1, 32'h0000_0200, 32'h2222_2222, 4'hF);
        run_until(done_count + 2, 30);

        // Lone instruction read, then tie: data first
        rd_value = 32'h1111_2222;
        bus_q.push_back({1'b0, 32'h0000_0104, 32'h0, 4'hF});
        rsp_q.push_back({1'b0, 32'h1111_2222});
        set_i(32'h0000_0104);
        run_until(done_count + 1, 20);
        rd_value = 32'h1111_3333;
        bus_q.push_back({1'b1, 32'h0000_0208, 32'h2222_AAAA, 4'b1100});
        bus_q.push_back({1'b0, 32'h0000_0108, 32'h0, 4'hF});
        rsp_q.push_back({1'b1, 32'h0});
        rsp_q.push_back({1'b0, 32'h1111_3333});
        set_i(32'h0000_0108);
        set_d(1'b1, 32'h0000_0208, 32'h2222_AAAA, 4'b1100);
        run_until(done_count + 2, 30);

        // Both held continuously: D, I, D, I
        auto_drop = 1'b0;
        rd_value = 32'h4444_4444;
        for (int n = 0; n < 2; n++) begin
            bus_q.push_back({1'b1, 32'h0000_0300, 32'h3333_3333, 4'b0101});
            bus_q.push_back({1'b0, 32'h0000_0404, 32'h0, 4'hF});
            rsp_q.push_back({1'b1, 32'h0});
            rsp_q.push_back({1'b0, 32'h4444_4444});
        end
        set_i(32'h0000_0406);
        set_d(1'b1, 32'h0000_0300, 32'h3333_3333, 4'b0101);
        run_until(done_count + 4, 40);
        i_req = 1'b0;
        d_req = 1'b0;
        auto_drop = 1'b1;
        tick();
        check("t4 idle after drop", dbg_state, 0);

        // Write with all byte lanes disabled still goes out
        bus_q.push_back({1'b1, 32'h0000_0500, 32'h0000_0055, 4'b0000});
        rsp_q.push_back({1'b1, 32'h0});
        set_d(1'b1, 32'h0000_0500, 32'h0000_0055, 4'b0000);
        run_until(done_count + 1, 20);

        // Reset while stalled in ISSUE: no done, bus released
        wait_cycles = 10;
        set_d(1'b0, 32'h0000_0600, 32'h0, 4'hF);
        tick();
        tick();
        check("t5 stalled read", read, 1);
        reset = 1'b1;
        tick();
        check("t5 read after reset", read, 0);
        check("t5 write after reset", write, 0);
        check("t5 state after reset", dbg_state, 0);
        check("t5 address after reset", address, 0);
        d_req = 1'b0;
        reset = 1'b0;
        wait_cycles = 0;
        for (int k = 0; k < 4; k++) tick();

        // Data read with 2 wait cycles
        wait_cycles = 2;
        rd_value = 32'h7777_0001;
        bus_q.push_back({1'b0, 32'h0000_0704, 32'h0, 4'hF});
        rsp_q.push_back({1'b1, 32'h7777_0001});
        set_d(1'b0, 32'h0000_0704, 32'h0, 4'hF);
        hits = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (d_done) hits++;
            check("t6 d_done timing", d_done, (k == 4));
        end
        check("t6 d_done cycles", hits, 1);
        wait_cycles = 0;

        for (int k = 0; k < 3; k++) tick();
        check("bus queue drained", bus_q.size(), 0);
        check("resp queue drained", rsp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
